// File: rtl/decode_stage.sv
// Pipelined RV32I(+M) decoder: combinational decode on the input side, a registered
// output bundle plus one skid entry, valid/ready on both sides, and an illegal-op counter.
module decode_stage #(
  parameter bit EN_MEXT  = 1'b0,
  parameter int CNT_W    = 16,
  parameter bit RD0_NOWB = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [7:0]       out_ctrl,
  output logic [4:0]       out_alu_ctrl,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_data_size,
  output logic [31:0]      out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  ctrl;
    logic [4:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  dsize;
    logic [31:0] imm;
    logic        ill;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_AND = 5'd2,  ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4,  ALU_SLL = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT = 5'd8,  ALU_SLTU = 5'd9, ALU_EQ = 5'd10,  ALU_NE   = 5'd11;
  localparam logic [4:0] ALU_GE  = 5'd12, ALU_GEU = 5'd13, ALU_PC4 = 5'd14, ALU_PASSB = 5'd15;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'd0:    base_alu = ALU_ADD;
      3'd1:    base_alu = ALU_SLL;
      3'd2:    base_alu = ALU_SLT;
      3'd3:    base_alu = ALU_SLTU;
      3'd4:    base_alu = ALU_XOR;
      3'd5:    base_alu = ALU_SRL;
      3'd6:    base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  state_t  state_q, state_d;
  bundle_t out_q, skid_q, dec;
  logic    in_fire, out_fire;
  logic    ld_out, ld_skid, skid_to_out;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        c_b, c_j, c_we, c_rfwe, c_sela, c_selb, c_wb, c_jalr, c_ill;
  logic [4:0]  c_alu;
  logic [31:0] c_imm;
  logic [2:0]  c_size;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    {c_b, c_j, c_we, c_rfwe, c_sela, c_selb, c_wb, c_jalr} = '0;
    c_alu  = ALU_ADD;
    c_imm  = '0;
    c_size = '0;
    c_ill  = 1'b0;
    case (opc)
      OPC_LOAD: begin
        c_rfwe = 1'b1; c_wb = 1'b1; c_selb = 1'b1; c_imm = imm_i; c_size = f3;
        c_ill  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        c_we = 1'b1; c_selb = 1'b1; c_imm = imm_s; c_size = f3;
        c_ill = (f3 > 3'd2);
      end
      OPC_OPIMM: begin
        c_rfwe = 1'b1; c_selb = 1'b1; c_imm = imm_i; c_alu = base_alu(f3);
        if (f3 == 3'd1) c_ill = (f7 != F7_ZERO);
        else if (f3 == 3'd5) begin
          if (f7 == F7_ALT) c_alu = ALU_SRA;
          else c_ill = (f7 != F7_ZERO);
        end
      end
      OPC_OP: begin
        c_rfwe = 1'b1;
        if (f7 == F7_ZERO) c_alu = base_alu(f3);
        else if (f7 == F7_ALT && f3 == 3'd0) c_alu = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'd5) c_alu = ALU_SRA;
        else if (f7 == F7_MUL && EN_MEXT) c_alu = {2'b10, f3};
        else c_ill = 1'b1;
      end
      OPC_LUI: begin
        c_rfwe = 1'b1; c_selb = 1'b1; c_alu = ALU_PASSB; c_imm = imm_u;
      end
      OPC_AUIPC: begin
        c_rfwe = 1'b1; c_sela = 1'b1; c_selb = 1'b1; c_imm = imm_u;
      end
      OPC_JAL: begin
        c_j = 1'b1; c_rfwe = 1'b1; c_sela = 1'b1; c_alu = ALU_PC4; c_imm = imm_j;
      end
      OPC_JALR: begin
        c_j = 1'b1; c_rfwe = 1'b1; c_sela = 1'b1; c_jalr = 1'b1; c_alu = ALU_PC4; c_imm = imm_i;
        c_ill = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        c_b = 1'b1; c_imm = imm_b;
        case (f3)
          3'd0:    c_alu = ALU_EQ;
          3'd1:    c_alu = ALU_NE;
          3'd4:    c_alu = ALU_SLT;
          3'd5:    c_alu = ALU_GE;
          3'd6:    c_alu = ALU_SLTU;
          3'd7:    c_alu = ALU_GEU;
          default: c_ill = 1'b1;
        endcase
      end
      OPC_FENCE: ;
      default:   c_ill = 1'b1;
    endcase
    // an illegal bundle must never change architectural state downstream
    if (c_ill) {c_b, c_j, c_we, c_rfwe} = '0;
    if (RD0_NOWB && in_instr[11:7] == 5'd0) c_rfwe = 1'b0;
  end

  always_comb begin
    dec.pc    = in_pc;
    dec.ctrl  = {c_b, c_j, c_we, c_rfwe, c_sela, c_selb, c_wb, c_jalr};
    dec.alu   = c_alu;
    dec.rs1   = in_instr[19:15];
    dec.rs2   = in_instr[24:20];
    dec.rd    = in_instr[11:7];
    dec.dsize = c_size;
    dec.imm   = c_imm;
    dec.ill   = c_ill;
  end

  assign in_ready  = (state_q != TWO) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ld_out      = 1'b0;
    ld_skid     = 1'b0;
    skid_to_out = 1'b0;
    if (flush) state_d = EMPTY;
    else begin
      case (state_q)
        EMPTY: if (in_fire) begin ld_out = 1'b1; state_d = ONE; end
        ONE: begin
          if (in_fire && out_ready) ld_out = 1'b1;
          else if (in_fire) begin ld_skid = 1'b1; state_d = TWO; end
          else if (out_ready) state_d = EMPTY;
        end
        TWO: if (out_ready) begin skid_to_out = 1'b1; state_d = ONE; end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (ld_out)           out_q <= dec;
      else if (skid_to_out) out_q <= skid_q;
      if (ld_skid)          skid_q <= dec;
    end
  end

  // counts on handoff, so a bundle drained in a flush cycle is still counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_cnt <= '0;
    else if (out_fire && out_q.ill && illegal_cnt != {CNT_W{1'b1}})
      illegal_cnt <= illegal_cnt + CNT_W'(1);
  end

  assign out_pc        = out_q.pc;
  assign out_ctrl      = out_q.ctrl;
  assign out_alu_ctrl  = out_q.alu;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_data_size = out_q.dsize;
  assign out_imm       = out_q.imm;
  assign out_illegal   = out_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode values, skid buffering, flush, illegal counting
// (with a narrow-counter instance for saturation) and async reset.
module tb_decode_stage;
  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [7:0]  out_ctrl;
  logic [4:0]  out_alu_ctrl, out_rs1, out_rs2, out_rd;
  logic [2:0]  out_data_size;
  logic [15:0] illegal_cnt;

  logic        n_in_ready, n_out_valid, n_out_illegal;
  logic [31:0] n_out_pc, n_out_imm;
  logic [7:0]  n_out_ctrl;
  logic [4:0]  n_out_alu_ctrl, n_out_rs1, n_out_rs2, n_out_rd;
  logic [2:0]  n_out_data_size;
  logic [1:0]  n_illegal_cnt;

  int n_chk = 0;
  int n_err = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .out_alu_ctrl(out_alu_ctrl), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_data_size(out_data_size), .out_imm(out_imm),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  decode_stage #(.CNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_out_pc), .out_ctrl(n_out_ctrl), .out_alu_ctrl(n_out_alu_ctrl), .out_rs1(n_out_rs1),
    .out_rs2(n_out_rs2), .out_rd(n_out_rd), .out_data_size(n_out_data_size), .out_imm(n_out_imm),
    .out_illegal(n_out_illegal), .illegal_cnt(n_illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(illegal_cnt), 32'd0);
    chk("rst_ctrl", 32'(out_ctrl), 32'd0);
    #4 rst = 1'b0;
    #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

    // addi x1,x2,-1
    out_ready = 1'b1;
    put(32'hFFF10093, 32'h100);
    tick;
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_alu", 32'(out_alu_ctrl), 32'd0);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_ctrl", 32'(out_ctrl), 32'h14);
    chk("addi_regs", {17'd0, out_rs1, out_rs2, out_rd}, {17'd0, 5'd2, 5'd31, 5'd1});
    chk("addi_pc", out_pc, 32'h100);
    in_valid = 1'b0;
    tick;
    chk("drain_valid", 32'(out_valid), 32'd0);

    // back-pressure: fill output and skid, third held off, then drain in order
    out_ready = 1'b0;
    put(32'h00100093, 32'h200);
    tick;
    put(32'h00200113, 32'h204);
    tick;
    chk("two_in_ready", 32'(in_ready), 32'd0);
    chk("two_imm_a", out_imm, 32'd1);
    put(32'h00300193, 32'h208);
    tick;
    chk("hold_imm_a", out_imm, 32'd1);
    chk("hold_pc_a", out_pc, 32'h200);
    out_ready = 1'b1;
    tick;
    chk("seq_imm_b", out_imm, 32'd2);
    chk("seq_pc_b", out_pc, 32'h204);
    chk("seq_in_ready", 32'(in_ready), 32'd1);
    tick;
    chk("seq_imm_c", out_imm, 32'd3);
    chk("seq_pc_c", out_pc, 32'h208);
    in_valid = 1'b0;
    tick;
    chk("seq_empty", 32'(out_valid), 32'd0);

    // lhu x5,4(x6) then sw x5,-8(x6)
    put(32'h00435283, 32'h300);
    tick;
    chk("lhu_size", 32'(out_data_size), 32'd5);
    chk("lhu_ctrl", 32'(out_ctrl), 32'h16);
    chk("lhu_imm", out_imm, 32'd4);
    put(32'hFE532C23, 32'h304);
    tick;
    chk("sw_ctrl", 32'(out_ctrl), 32'h24);
    chk("sw_size", 32'(out_data_size), 32'd2);
    chk("sw_imm", out_imm, 32'hFFFFFFF8);
    put(32'h00000013, 32'h308);           // addi x0,x0,0: no writeback to x0
    tick;
    chk("nop_ctrl", 32'(out_ctrl), 32'h04);
    put(32'h00208463, 32'h30C);           // beq x1,x2,+8
    tick;
    chk("beq_ctrl", 32'(out_ctrl), 32'h80);
    chk("beq_alu", 32'(out_alu_ctrl), 32'd10);
    chk("beq_imm", out_imm, 32'd8);
    in_valid = 1'b0;
    tick;
    chk("pre_ill_cnt", 32'(illegal_cnt), 32'd0);

    // illegal: zero word, ecall, mul without M extension
    put(32'h00000000, 32'h400);
    tick;
    chk("zero_ill", 32'(out_illegal), 32'd1);
    chk("zero_ctrl_hi", 32'(out_ctrl[7:4]), 32'd0);
    put(32'h00000073, 32'h404);
    tick;
    chk("ecall_ill", 32'(out_illegal), 32'd1);
    chk("ecall_ctrl_hi", 32'(out_ctrl[7:4]), 32'd0);
    put(32'h023100B3, 32'h408);
    tick;
    chk("mul_ill", 32'(out_illegal), 32'd1);
    chk("mul_ctrl_hi", 32'(out_ctrl[7:4]), 32'd0);
    in_valid = 1'b0;
    tick;
    chk("cnt3", 32'(illegal_cnt), 32'd3);
    chk("ncnt3", 32'(n_illegal_cnt), 32'd3);
    put(32'h00003003, 32'h40C);           // load funct3=3
    tick;
    chk("ld3_ill", 32'(out_illegal), 32'd1);
    put(32'h00002063, 32'h410);           // branch funct3=2
    tick;
    chk("br2_ill", 32'(out_illegal), 32'd1);
    in_valid = 1'b0;
    tick;
    chk("cnt5", 32'(illegal_cnt), 32'd5);
    chk("ncnt_sat", 32'(n_illegal_cnt), 32'd3);

    // flush from TWO with a live input, then flush from EMPTY
    out_ready = 1'b0;
    put(32'h00100093, 32'h500);
    tick;
    put(32'h00200113, 32'h504);
    tick;
    chk("fl_two", 32'(in_ready), 32'd0);
    flush = 1'b1;
    put(32'h00700393, 32'h508);
    tick;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick;
    chk("fl_gone", 32'(out_valid), 32'd0);
    flush = 1'b1;
    put(32'h00700393, 32'h50C);
    tick;
    chk("fl_empty_drop", 32'(out_valid), 32'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    put(32'h00900493, 32'h510);
    tick;
    chk("post_fl_valid", 32'(out_valid), 32'd1);
    chk("post_fl_imm", out_imm, 32'd9);
    chk("post_fl_pc", out_pc, 32'h510);

    // async reset between edges mid-stream
    put(32'h00A00513, 32'h600);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd0);
    chk("ar_imm", out_imm, 32'd0);
    chk("ar_cnt", 32'(illegal_cnt), 32'd0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    put(32'h00435283, 32'h700);
    tick;
    chk("ar_lhu_valid", 32'(out_valid), 32'd1);
    chk("ar_lhu_size", 32'(out_data_size), 32'd5);
    chk("ar_lhu_imm", out_imm, 32'd4);
    chk("ar_lhu_pc", out_pc, 32'h700);
    in_valid = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
